// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the Turtle CPU: gates the per-cycle execute enable,
// records why the core last stopped and keeps a saturating count of executed cycles.
module cpu_run_ctrl #(
  parameter int I_ADDR_W     = 12,
  parameter int CNT_W        = 32,
  parameter int STARTUP_HALT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run_pulse,
  input  logic                halt_pulse,
  input  logic                step_pulse,
  input  logic                bp_en,
  input  logic [I_ADDR_W-1:0] bp_addr,
  input  logic [I_ADDR_W-1:0] pc,
  input  logic                halt_inst,
  input  logic                clr_count,
  output logic                cpu_en,
  output logic                halted,
  output logic [2:0]          halt_cause,
  output logic [CNT_W-1:0]    instr_count
);

  localparam logic [2:0] CAUSE_RESET     = 3'd0;
  localparam logic [2:0] CAUSE_EXT       = 3'd1;
  localparam logic [2:0] CAUSE_STEP      = 3'd2;
  localparam logic [2:0] CAUSE_BP        = 3'd3;
  localparam logic [2:0] CAUSE_HALT_INST = 3'd4;

  typedef enum logic [1:0] {
    S_HALTED    = 2'd0,
    S_RUN_FIRST = 2'd1,
    S_RUNNING   = 2'd2,
    S_STEP      = 2'd3
  } state_t;

  localparam state_t RESET_STATE  = (STARTUP_HALT != 0) ? S_HALTED : S_RUN_FIRST;
  localparam logic   RESET_HALTED = (STARTUP_HALT != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t state;
  logic   bp_hit;
  logic   en_raw;

  assign bp_hit = bp_en && (pc == bp_addr);

  // RUN_FIRST ignores the breakpoint so a resume from the BP address makes progress;
  // STEP commits to its single instruction unless it is a HALT.
  always_comb begin
    en_raw = 1'b0;
    case (state)
      S_HALTED:    en_raw = 1'b0;
      S_RUN_FIRST: en_raw = !halt_inst && !halt_pulse;
      S_RUNNING:   en_raw = !halt_inst && !halt_pulse && !bp_hit;
      S_STEP:      en_raw = !halt_inst;
      default:     en_raw = 1'b0;
    endcase
    cpu_en = reset_n && en_raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      halted     <= RESET_HALTED;
      halt_cause <= CAUSE_RESET;
    end else begin
      case (state)
        S_HALTED: begin
          if (step_pulse) begin
            state  <= S_STEP;
            halted <= 1'b0;
          end else if (run_pulse) begin
            state  <= S_RUN_FIRST;
            halted <= 1'b0;
          end
        end
        S_RUN_FIRST: begin
          if (halt_pulse) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            halt_cause <= CAUSE_EXT;
          end else if (halt_inst) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            halt_cause <= CAUSE_HALT_INST;
          end else begin
            state <= S_RUNNING;
          end
        end
        S_RUNNING: begin
          if (halt_pulse) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            halt_cause <= CAUSE_EXT;
          end else if (halt_inst) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            halt_cause <= CAUSE_HALT_INST;
          end else if (bp_hit) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            halt_cause <= CAUSE_BP;
          end
        end
        S_STEP: begin
          state      <= S_HALTED;
          halted     <= 1'b1;
          halt_cause <= halt_inst ? CAUSE_HALT_INST : CAUSE_STEP;
        end
        default: begin
          state      <= S_HALTED;
          halted     <= 1'b1;
          halt_cause <= CAUSE_RESET;
        end
      endcase
    end
  end

  // Clear beats increment; the count tracks retirements regardless of state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (clr_count) begin
      instr_count <= '0;
    end else if (cpu_en) begin
      instr_count <= sat_inc(instr_count);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Vector-table bench for cpu_run_ctrl: cpu_en checked in-cycle, registered outputs
// checked after the edge through an expectation queue.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run_pulse, halt_pulse, step_pulse, bp_en, halt_inst, clr_count;
  logic [11:0] bp_addr, pc;
  logic        cpu_en, halted;
  logic [2:0]  halt_cause;
  logic [3:0]  instr_count;

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_ctrl #(.I_ADDR_W(12), .CNT_W(4), .STARTUP_HALT(1)) dut (
    .clk(clk), .reset_n(reset_n), .run_pulse(run_pulse), .halt_pulse(halt_pulse),
    .step_pulse(step_pulse), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .halt_inst(halt_inst), .clr_count(clr_count), .cpu_en(cpu_en), .halted(halted),
    .halt_cause(halt_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run, halt, step, bpe;
    logic [11:0] bpa, pcv;
    logic       hi, clr;
    logic       en, hd;
    logic [2:0] cause;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic       hd;
    logic [2:0] cause;
    logic [3:0] cnt;
  } sb_t;

  vec_t vq[$];
  sb_t  sb[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic run, input logic halt, input logic step, input logic bpe,
                     input logic [11:0] bpa, input logic [11:0] pcv, input logic hi, input logic clr,
                     input logic en, input logic hd, input logic [2:0] cause, input logic [3:0] cnt);
    vec_t v;
    v.run = run; v.halt = halt; v.step = step; v.bpe = bpe; v.bpa = bpa; v.pcv = pcv;
    v.hi = hi; v.clr = clr; v.en = en; v.hd = hd; v.cause = cause; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    @(negedge clk);
    run_pulse = v.run; halt_pulse = v.halt; step_pulse = v.step; bp_en = v.bpe;
    bp_addr = v.bpa; pc = v.pcv; halt_inst = v.hi; clr_count = v.clr;
    #1;
    chk("cpu_en", idx, {31'd0, cpu_en}, {31'd0, v.en});
    e.idx = idx; e.hd = v.hd; e.cause = v.cause; e.cnt = v.cnt;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      #1;
      e = sb.pop_front();
      chk("halted", e.idx, {31'd0, halted}, {31'd0, e.hd});
      chk("halt_cause", e.idx, {29'd0, halt_cause}, {29'd0, e.cause});
      chk("instr_count", e.idx, {28'd0, instr_count}, {28'd0, e.cnt});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset_n = 1'b0;
    run_pulse = 0; halt_pulse = 0; step_pulse = 0; bp_en = 0; halt_inst = 0; clr_count = 0;
    bp_addr = 12'h010; pc = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_en", 0, {31'd0, cpu_en}, 32'd0);
    chk("rst_halted", 0, {31'd0, halted}, 32'd1);
    chk("rst_cause", 0, {29'd0, halt_cause}, 32'd0);
    chk("rst_count", 0, {28'd0, instr_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // free run of 10 then external halt
    add(0,0,0,0,12'h010,12'h000,0,0, 0,1,3'd0,4'd0);
    add(0,1,0,0,12'h010,12'h000,0,0, 0,1,3'd0,4'd0);
    add(1,0,0,0,12'h010,12'h000,0,0, 0,0,3'd0,4'd0);
    for (int i = 0; i < 10; i++) add(0,0,0,0,12'h010,12'(i),0,0, 1,0,3'd0,4'(i+1));
    add(0,1,0,0,12'h010,12'h00A,0,0, 0,1,3'd1,4'd10);
    add(0,0,0,0,12'h010,12'h00A,0,1, 0,1,3'd1,4'd0);
    // three single steps, 5 cycles apart
    for (int k = 0; k < 3; k++) begin
      add(0,0,1,0,12'h010,12'(32+k),0,0, 0,0,(k == 0) ? 3'd1 : 3'd2,4'(k));
      add(0,0,0,0,12'h010,12'(32+k),0,0, 1,1,3'd2,4'(k+1));
      for (int j = 0; j < 3; j++) add(0,0,0,0,12'h010,12'(33+k),0,0, 0,1,3'd2,4'(k+1));
    end
    // breakpoint at 0x010, counter saturates along the way
    add(1,0,0,1,12'h010,12'h000,0,1, 0,0,3'd2,4'd0);
    for (int i = 0; i < 16; i++) add(0,0,0,1,12'h010,12'(i),0,0, 1,0,3'd2,(i+1 > 15) ? 4'd15 : 4'(i+1));
    add(0,0,0,1,12'h010,12'h010,0,0, 0,1,3'd3,4'd15);
    add(1,0,0,1,12'h010,12'h010,0,1, 0,0,3'd3,4'd0);
    add(0,0,0,1,12'h010,12'h010,0,0, 1,0,3'd3,4'd1);
    add(0,0,0,1,12'h010,12'h011,0,0, 1,0,3'd3,4'd2);
    add(0,0,0,1,12'h010,12'h012,0,0, 1,0,3'd3,4'd3);
    add(0,1,0,1,12'h010,12'h013,0,0, 0,1,3'd1,4'd3);
    // HALT instruction: never executes, terminal for run and step
    add(1,0,0,0,12'h010,12'h020,0,0, 0,0,3'd1,4'd3);
    add(0,0,0,0,12'h010,12'h020,0,0, 1,0,3'd1,4'd4);
    add(0,0,0,0,12'h010,12'h021,0,0, 1,0,3'd1,4'd5);
    add(0,0,0,0,12'h010,12'h022,1,0, 0,1,3'd4,4'd5);
    add(0,0,1,0,12'h010,12'h022,1,0, 0,0,3'd4,4'd5);
    add(0,0,0,0,12'h010,12'h022,1,0, 0,1,3'd4,4'd5);
    add(1,0,0,0,12'h010,12'h022,1,0, 0,0,3'd4,4'd5);
    add(0,0,0,0,12'h010,12'h022,1,0, 0,1,3'd4,4'd5);
    // halt priorities and simultaneous requests
    add(1,0,0,1,12'h010,12'h00F,0,0, 0,0,3'd4,4'd5);
    add(0,0,0,1,12'h010,12'h00F,0,0, 1,0,3'd4,4'd6);
    add(0,1,0,1,12'h010,12'h010,0,0, 0,1,3'd1,4'd6);
    add(1,0,0,1,12'h031,12'h030,0,0, 0,0,3'd1,4'd6);
    add(0,0,0,1,12'h031,12'h030,0,0, 1,0,3'd1,4'd7);
    add(0,0,0,1,12'h031,12'h031,1,0, 0,1,3'd4,4'd7);
    add(1,0,0,1,12'h031,12'h031,0,0, 0,0,3'd4,4'd7);
    add(0,1,0,1,12'h031,12'h031,0,0, 0,1,3'd1,4'd7);
    add(1,0,1,0,12'h010,12'h040,0,0, 0,0,3'd1,4'd7);
    add(0,0,0,0,12'h010,12'h040,0,0, 1,1,3'd2,4'd8);
    add(0,0,0,0,12'h010,12'h041,0,0, 0,1,3'd2,4'd8);
    add(0,0,1,1,12'h042,12'h041,0,0, 0,0,3'd2,4'd8);
    add(0,1,0,1,12'h042,12'h042,0,0, 1,1,3'd2,4'd9);
    // full-width breakpoint compare: upper bit differs, no hit
    add(1,0,0,1,12'h010,12'h810,0,0, 0,0,3'd2,4'd9);
    add(0,0,0,1,12'h010,12'h810,0,0, 1,0,3'd2,4'd10);
    add(0,0,0,1,12'h010,12'h810,0,0, 1,0,3'd2,4'd11);
    add(0,0,0,1,12'h010,12'h010,0,0, 0,1,3'd3,4'd11);
    // saturation at 15, clear with cpu_en high, step ignored while running
    add(0,0,0,0,12'h010,12'h000,0,1, 0,1,3'd3,4'd0);
    add(1,0,0,0,12'h010,12'h000,0,0, 0,0,3'd3,4'd0);
    for (int i = 0; i < 14; i++) add(0,0,0,0,12'h010,12'(256+i),0,0, 1,0,3'd3,4'(i+1));
    for (int i = 0; i < 5; i++) add(0,0,0,0,12'h010,12'(272+i),0,0, 1,0,3'd3,4'd15);
    add(0,0,0,0,12'h010,12'h200,0,1, 1,0,3'd3,4'd0);
    add(0,0,0,0,12'h010,12'h201,0,0, 1,0,3'd3,4'd1);
    add(0,0,1,0,12'h010,12'h202,0,0, 1,0,3'd3,4'd2);
    add(0,0,0,0,12'h010,12'h203,0,0, 1,0,3'd3,4'd3);
    add(0,1,0,0,12'h010,12'h204,0,0, 0,1,3'd1,4'd3);
    add(0,0,1,0,12'h010,12'h300,0,0, 0,0,3'd1,4'd3);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i + 1);

    // reset asserted mid-STEP: enable drops at once, no credit for the step
    @(negedge clk);
    #1;
    chk("step_cpu_en", 900, {31'd0, cpu_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rststep_cpu_en", 900, {31'd0, cpu_en}, 32'd0);
    chk("rststep_halted", 900, {31'd0, halted}, 32'd1);
    chk("rststep_cause", 900, {29'd0, halt_cause}, 32'd0);
    chk("rststep_count", 900, {28'd0, instr_count}, 32'd0);
    step_pulse = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    v.run = 0; v.halt = 0; v.step = 0; v.bpe = 0; v.bpa = 12'h010; v.pcv = 12'h300;
    v.hi = 0; v.clr = 0; v.en = 0; v.hd = 1; v.cause = 3'd0; v.cnt = 4'd0;
    apply(v, 901);
    @(posedge clk);
    #3;
    chk("sb_drained", 902, sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the Turtle CPU subsystem. Sits between the clock/reset generator and the CPU subsystem and drives a per-cycle instruction-execute enable. Provides halt on external request, PC breakpoint, HALT instruction and single-step completion. Keeps a saturating count of executed cycles for debug.

## Interface
- I_ADDR_W, 12, width of instruction address / PC
- CNT_W, 32, width of executed-cycle counter
- STARTUP_HALT, 1, 1: come out of reset HALTED; 0: come out of reset running (RUN_FIRST)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- run_pulse  in  1  one-cycle request to start free-running (already synchronized/debounced)
- halt_pulse  in  1  one-cycle request to stop
- step_pulse  in  1  one-cycle request to execute exactly one instruction
- bp_en  in  1  breakpoint enable
- bp_addr  in  I_ADDR_W  breakpoint PC
- pc  in  I_ADDR_W  PC of the instruction that would execute this cycle
- halt_inst  in  1  decoder flag: instruction at pc is HALT
- clr_count  in  1  synchronous clear of instr_count
- cpu_en  out  1  execute enable to CPU subsystem; high = instruction at pc retires this cycle
- halted  out  1  registered, high when state is HALTED
- halt_cause  out  3  0 RESET, 1 EXT, 2 STEP, 3 BP, 4 HALT_INST
- instr_count  out  CNT_W  cycles with cpu_en high, saturating

## Operation
- States: HALTED, RUN_FIRST, RUNNING, STEP.
- Reset: state = HALTED (STARTUP_HALT=1) or RUN_FIRST (0); halted = STARTUP_HALT; halt_cause = 0; instr_count = 0; cpu_en = 0 while reset_n low.
- bp_hit = bp_en && (pc == bp_addr), full-width compare.
- cpu_en (combinational, Mealy):
  - HALTED: 0.
  - RUN_FIRST: !halt_inst && !halt_pulse (breakpoint ignored so resume from a BP address makes progress).
  - RUNNING: !halt_inst && !halt_pulse && !bp_hit.
  - STEP: !halt_inst (halt_pulse and breakpoint ignored).
- Transitions:
  - HALTED: step_pulse -> STEP; else run_pulse -> RUN_FIRST; halt_pulse ignored. Priority step > run.
  - RUN_FIRST: halt_pulse -> HALTED/EXT; else halt_inst -> HALTED/HALT_INST; else -> RUNNING.
  - RUNNING: halt_pulse -> HALTED/EXT; else halt_inst -> HALTED/HALT_INST; else bp_hit -> HALTED/BP; else stay. Priority EXT > HALT_INST > BP.
  - STEP: halt_inst -> HALTED/HALT_INST; else -> HALTED/STEP.
  - run_pulse/step_pulse ignored outside HALTED.
- halt_cause updates only on entry to HALTED; holds otherwise.
- HALT instruction is never executed; run/step while pc points at HALT re-halts with HALT_INST and cpu_en stays 0 (terminal until reset).
- instr_count: +1 on each cpu_en cycle; saturates at 2^CNT_W-1; clr_count wins over increment; independent of state.

## Timing
- run_pulse in HALTED at cycle N -> RUN_FIRST at N+1, cpu_en high from N+1 (given no halt condition), halted low at N+1.
- step_pulse at N -> cpu_en high only in N+1 -> halted high at N+2, halt_cause = 2.
- halt_pulse in RUNNING at N -> cpu_en low in N; halted high at N+1.
- Breakpoint: pc==bp_addr in RUNNING at N -> instruction not executed (cpu_en low in N); halted at N+1, cause 3.
- Reset mid-operation: immediate async return to reset state; no partial step credited.
- instr_count reflects cycle N's cpu_en at N+1.

## Test plan
- Reset with STARTUP_HALT=1 -> halted=1, halt_cause=0, cpu_en=0, instr_count=0; run_pulse -> cpu_en high next cycle, instr_count 10 after 10 cycles.
- Halted, three step_pulses 5 cycles apart -> exactly 3 one-cycle cpu_en pulses, instr_count=3, halt_cause=2.
- bp_en=1, bp_addr=0x010, pc increments from 0x000 -> cpu_en low at pc=0x010, halt_cause=3; run_pulse -> executes 0x010 (RUN_FIRST), continues to 0x011.
- halt_inst asserted while RUNNING -> cpu_en low same cycle, halt_cause=4; step_pulse -> no cpu_en, cause 4 again.
- Simultaneous halt_pulse and bp_hit in RUNNING -> cause 1; simultaneous run_pulse+step_pulse in HALTED -> single step only.
- Force instr_count to 2^CNT_W-2 (CNT_W=4: 14), run 5 cycles -> holds 15; clr_count with cpu_en high -> 0; reset_n low during STEP -> cpu_en 0 immediately, state per STARTUP_HALT.
